// File: rtl/capadj_trim_ctrl.sv
// capadj_trim_ctrl: drives the 3-bit capacitoradjust pin of the adjustable
// MIM capacitor bricks. Ramps to a requested code one LSB per dwell period
// and runs a 3-step SAR calibration against a synchronized loop comparator.
module capadj_trim_ctrl #(
  parameter logic [2:0] POR_CODE = 3'd7,
  parameter int         DWELL    = 16,
  parameter int         SETTLE   = 32
) (
  input  logic       CELCLK,
  input  logic       CELRSTB,
  input  logic       req,
  input  logic [2:0] code_in,
  output logic       ack,
  input  logic       cal_start,
  input  logic       cmp,
  output logic       cal_done,
  output logic [2:0] cal_code,
  output logic       busy,
  output logic [2:0] capacitoradjust
);

  localparam logic [7:0] DWELL_M1  = 8'(DWELL - 1);
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RAMP  = 3'd1,
    S_ACK   = 3'd2,
    S_CAL   = 3'd3,
    S_CDONE = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic [2:0] tgt_q, tgt_d;
  logic [7:0] cnt_q, cnt_d;      // shared dwell / settle timer
  logic [1:0] bit_q, bit_d;      // SAR trial bit index
  logic [2:0] res_q, res_d;      // SAR partial result
  logic [2:0] calc_q, calc_d;
  logic       ack_q, ack_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       sync1_q, sync2_q;

  logic [2:0] step_s;
  logic [2:0] new_r_s;

  // One-hot mask for a SAR bit index.
  function automatic logic [2:0] bit_mask(input logic [1:0] idx);
    logic [2:0] m;
    case (idx)
      2'd0:    m = 3'b001;
      2'd1:    m = 3'b010;
      2'd2:    m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  // Two-flop synchronizer for the asynchronous comparator.
  always_ff @(posedge CELCLK) begin
    if (!CELRSTB) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= cmp;
      sync2_q <= sync1_q;
    end
  end

  // Next-state and registered-output logic for ramp and calibration.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    res_d   = res_q;
    calc_d  = calc_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    step_s  = (tgt_q > code_q) ? (code_q + 3'd1) : (code_q - 3'd1);
    new_r_s = sync2_q ? (res_q | bit_mask(bit_q)) : res_q;
    case (state_q)
      S_IDLE: begin
        if (cal_start) begin
          // Calibration wins over a simultaneous ramp request.
          state_d = S_CAL;
          code_d  = 3'b100;
          cnt_d   = SETTLE_M1;
          bit_d   = 2'd2;
          res_d   = 3'b000;
        end else if (req) begin
          tgt_d = code_in;
          if (code_in == code_q) begin
            state_d = S_ACK;   // null ramp: ack follows one cycle later
          end else begin
            state_d = S_RAMP;
            cnt_d   = DWELL_M1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RAMP: begin
        if (cnt_q == 8'd0) begin
          code_d = step_s;
          cnt_d  = DWELL_M1;
          if (step_s == tgt_q) begin
            state_d = S_ACK;
            ack_d   = 1'b1;
          end else begin
            state_d = S_RAMP;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_ACK: begin
        // ack_q already high means the pulse is being shown now.
        if (ack_q) begin
          state_d = S_IDLE;
        end else begin
          ack_d = 1'b1;
        end
      end
      S_CAL: begin
        if (cnt_q == 8'd0) begin
          res_d = new_r_s;
          if (bit_q != 2'd0) begin
            code_d = new_r_s | bit_mask(bit_q - 2'd1);
            cnt_d  = SETTLE_M1;
            bit_d  = bit_q - 2'd1;
          end else begin
            code_d  = new_r_s;
            calc_d  = new_r_s;
            done_d  = 1'b1;
            state_d = S_CDONE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_CDONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CELCLK) begin
    if (!CELRSTB) begin
      state_q <= S_IDLE;
      code_q  <= POR_CODE;
      tgt_q   <= POR_CODE;
      cnt_q   <= 8'd0;
      bit_q   <= 2'd0;
      res_q   <= 3'd0;
      calc_q  <= POR_CODE;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      res_q   <= res_d;
      calc_q  <= calc_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign capacitoradjust = code_q;
  assign cal_code        = calc_q;
  assign ack             = ack_q;
  assign cal_done        = done_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_capadj_trim_ctrl.sv
// Testbench for capadj_trim_ctrl: directed stimulus, a timing-formula model
// compared every cycle, plus hand-computed literal expectations.
module tb_capadj_trim_ctrl;

  localparam int D = 4;
  localparam int S = 8;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       req = 1'b0;
  logic [2:0] code_in = 3'd0;
  logic       cal_start = 1'b0;
  logic       cmp;
  logic       ack, cal_done, busy;
  logic [2:0] cal_code, capacitoradjust;
  int         cmp_mode = 0;   // 0: code<=5, 1: always 0, 2: always 1

  int checks = 0;
  int failures = 0;

  // model state
  int ec = 0, mmode = 0, mk = 0, mcode0 = 7, mtgt = 7, mn = 0;
  int mt1 = 0, mt2 = 0, mres = 0;
  int e_code = 7, e_calc = 7, e_ack = 0, e_done = 0, e_busy = 0;
  int ack_cnt, busy_cnt, done_cnt;

  capadj_trim_ctrl #(.POR_CODE(3'd7), .DWELL(D), .SETTLE(S)) dut (
    .CELCLK(clk), .CELRSTB(rstb), .req(req), .code_in(code_in), .ack(ack),
    .cal_start(cal_start), .cmp(cmp), .cal_done(cal_done), .cal_code(cal_code),
    .busy(busy), .capacitoradjust(capacitoradjust)
  );

  always #5 clk = ~clk;

  // comparator environment model driven from the brick code
  assign cmp = (cmp_mode == 0) ? (capacitoradjust <= 3'd5) : (cmp_mode == 2);

  function automatic int fcmp(input int c);
    if (cmp_mode == 0) return (c <= 5) ? 1 : 0;
    else if (cmp_mode == 2) return 1;
    else return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update at an active edge, from the pre-edge inputs.
  task automatic model_edge();
    int d, st, b2, b1, b0;
    ec++;
    e_ack = 0;
    e_done = 0;
    if (!rstb) begin
      mmode = 0; e_code = 7; e_calc = 7; e_busy = 0;
    end else begin
      case (mmode)
        0: begin
          if (cal_start) begin
            b2 = fcmp(4);
            mt1 = b2 * 4 + 2;
            b1 = fcmp(mt1);
            mt2 = b2 * 4 + b1 * 2 + 1;
            b0 = fcmp(mt2);
            mres = b2 * 4 + b1 * 2 + b0;
            mk = ec; mmode = 2; e_code = 4; e_busy = 1;
          end else if (req) begin
            mtgt = int'(code_in); mcode0 = e_code; mk = ec; e_busy = 1;
            mn = (mtgt > mcode0) ? mtgt - mcode0 : mcode0 - mtgt;
            mmode = (mn == 0) ? 3 : 1;
          end
        end
        1: begin
          d = ec - mk;
          if (d % D == 0) begin
            st = d / D;
            e_code = (mtgt > mcode0) ? mcode0 + st : mcode0 - st;
            if (st == mn) begin e_ack = 1; mmode = 4; end
          end
        end
        3: begin e_ack = 1; mmode = 4; end
        2: begin
          d = ec - mk;
          if (d == S) e_code = mt1;
          else if (d == 2 * S) e_code = mt2;
          else if (d == 3 * S) begin
            e_code = mres; e_calc = mres; e_done = 1; mmode = 5;
          end
        end
        default: begin e_busy = 0; mmode = 0; end
      endcase
    end
  endtask

  // One clock: model at posedge, compare at negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("code", int'(capacitoradjust), e_code);
    chk("cal_code", int'(cal_code), e_calc);
    chk("ack", int'(ack), e_ack);
    chk("cal_done", int'(cal_done), e_done);
    chk("busy", int'(busy), e_busy);
    ack_cnt += int'(ack);
    busy_cnt += int'(busy);
    done_cnt += int'(cal_done);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // reset / POR
    steps(3);
    rstb = 1'b1;
    step();
    chk("por_code", int'(capacitoradjust), 7);
    chk("por_cal_code", int'(cal_code), 7);
    chk("por_busy", int'(busy), 0);

    // downward ramp 7 -> 4
    req = 1'b1; code_in = 3'd4; step(); req = 1'b0;
    chk("ramp_busy_k", int'(busy), 1);
    steps(4); chk("ramp_k4", int'(capacitoradjust), 6);
    steps(4); chk("ramp_k8", int'(capacitoradjust), 5);
    steps(4); chk("ramp_k12", int'(capacitoradjust), 4);
    chk("ramp_ack", int'(ack), 1);
    step(); chk("ramp_busy_end", int'(busy), 0);

    // null request
    req = 1'b1; code_in = 3'd4; step(); req = 1'b0;
    chk("null_ack_k", int'(ack), 0);
    step(); chk("null_ack_k1", int'(ack), 1);
    chk("null_code", int'(capacitoradjust), 4);
    step();

    // ramp to 7 with an ignored mid-ramp request
    ack_cnt = 0;
    req = 1'b1; code_in = 3'd7; step(); req = 1'b0;
    steps(2);
    req = 1'b1; code_in = 3'd0; step(); req = 1'b0;
    steps(20);
    chk("ign_ack_count", ack_cnt, 1);
    chk("ign_code", int'(capacitoradjust), 7);

    // calibration, cmp = code<=5
    cmp_mode = 0;
    cal_start = 1'b1; step(); cal_start = 1'b0;
    chk("cal_trial0", int'(capacitoradjust), 4);
    steps(8); chk("cal_trial1", int'(capacitoradjust), 6);
    steps(8); chk("cal_trial2", int'(capacitoradjust), 5);
    steps(8); chk("cal_res", int'(cal_code), 5);
    chk("cal_done_pulse", int'(cal_done), 1);
    step();

    // calibration, cmp always 0 / always 1
    cmp_mode = 1;
    cal_start = 1'b1; step(); cal_start = 1'b0;
    steps(24); chk("cal0_res", int'(cal_code), 0);
    step();
    cmp_mode = 2;
    cal_start = 1'b1; step(); cal_start = 1'b0;
    steps(24); chk("cal1_res", int'(cal_code), 7);
    chk("cal1_code", int'(capacitoradjust), 7);
    step();

    // priority: cal_start beats req
    cmp_mode = 0; ack_cnt = 0; busy_cnt = 0;
    req = 1'b1; code_in = 3'd2; cal_start = 1'b1; step();
    req = 1'b0; cal_start = 1'b0;
    steps(29);
    chk("prio_ack_count", ack_cnt, 0);
    chk("prio_busy_cycles", busy_cnt, 3 * S + 1);
    chk("prio_res", int'(cal_code), 5);

    // reset mid-ramp at code 5
    ack_cnt = 0;
    req = 1'b1; code_in = 3'd0; step(); req = 1'b0;
    steps(2);
    rstb = 1'b0; step(); rstb = 1'b1;
    chk("rst_ramp_code", int'(capacitoradjust), 7);
    chk("rst_ramp_busy", int'(busy), 0);
    steps(10);
    chk("rst_ramp_ack", ack_cnt, 0);

    // reset mid-calibration at trial 6
    done_cnt = 0;
    cal_start = 1'b1; step(); cal_start = 1'b0;
    steps(8); chk("rst_cal_trial", int'(capacitoradjust), 6);
    steps(2);
    rstb = 1'b0; step(); rstb = 1'b1;
    chk("rst_cal_code", int'(capacitoradjust), 7);
    chk("rst_cal_calcode", int'(cal_code), 7);
    steps(30);
    chk("rst_cal_done", done_cnt, 0);

    // following request accepted normally
    req = 1'b1; code_in = 3'd6; step(); req = 1'b0;
    steps(4);
    chk("post_code", int'(capacitoradjust), 6);
    chk("post_ack", int'(ack), 1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
